// File: rtl/vc_arb_mux_pkg.sv
// Shared helpers for vc_arb_mux: channel-index width and output-stage state encoding.
// Build macro VC_ARB_MUX_RR_EN selects round-robin arbitration (fixed priority otherwise).
package vc_arb_mux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic int chan_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// Combinational rotating-priority arbiter: channel prio wins first, then ascending index mod NUM_CH.
// Used by vc_arb_mux (macro VC_ARB_MUX_RR_EN decides whether prio actually rotates).
module vc_rr_arbiter
  import vc_arb_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CHAN_W = chan_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CHAN_W-1:0] prio,
  output logic [NUM_CH-1:0] grant,
  output logic [CHAN_W-1:0] grant_idx
);

  always_comb begin
    int   w_base;
    int   w_idx;
    logic w_found;
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    // An out-of-range pointer cannot be produced by the parent, but falls back to 0 safely.
    w_base    = (int'(prio) < NUM_CH) ? int'(prio) : 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = w_base + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_found && req[w_idx]) begin
        w_found        = 1'b1;
        grant[w_idx]   = 1'b1;
        grant_idx      = CHAN_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/vc_arb_mux.sv
// N-channel val/rdy arbitrating mux with a one-entry registered output stage.
// VC_ARB_MUX_RR_EN defined: round-robin pointer; undefined: fixed lowest-index priority.
module vc_arb_mux
  import vc_arb_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 32,
  localparam int CHAN_W = chan_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       in_val,
  output logic [NUM_CH-1:0]       in_rdy,
  input  logic [NUM_CH*WIDTH-1:0] in_msg,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [WIDTH-1:0]        out_msg,
  output logic [CHAN_W-1:0]       out_chan
);

  out_state_e        r_state;
  logic [WIDTH-1:0]  r_msg;
  logic [CHAN_W-1:0] r_chan;

  logic [NUM_CH-1:0] w_grant;
  logic [CHAN_W-1:0] w_grant_idx;
  logic [CHAN_W-1:0] w_prio;
  logic              w_space;
  logic              w_load;
  logic [WIDTH-1:0]  w_masked [NUM_CH];
  logic [WIDTH-1:0]  w_mux;

  vc_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (in_val),
    .prio      (w_prio),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_space = (r_state == ST_EMPTY) | out_rdy;
  assign w_load  = (|in_val) & w_space;
  assign in_rdy  = w_grant & {NUM_CH{w_space}};

`ifdef VC_ARB_MUX_RR_EN
  logic [CHAN_W-1:0] r_prio;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio <= '0;
    end else if (w_load) begin
      r_prio <= (w_grant_idx == CHAN_W'(NUM_CH - 1)) ? '0 : w_grant_idx + CHAN_W'(1);
    end
  end

  assign w_prio = r_prio;
`else
  assign w_prio = '0;
`endif

  // One-hot AND-OR select keeps in_msg off every combinational output path.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
    assign w_masked[gi] = in_msg[gi*WIDTH +: WIDTH] & {WIDTH{w_grant[gi]}};
  end

  always_comb begin
    w_mux = '0;
    for (int i = 0; i < NUM_CH; i++) w_mux = w_mux | w_masked[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
      r_msg   <= '0;
      r_chan  <= '0;
    end else if (w_load) begin
      r_state <= ST_FULL;
      r_msg   <= w_mux;
      r_chan  <= w_grant_idx;
    end else if (out_rdy) begin
      r_state <= ST_EMPTY;
    end
  end

  assign out_val  = (r_state == ST_FULL);
  assign out_msg  = r_msg;
  assign out_chan = r_chan;

endmodule

// File: tb/tb_vc_arb_mux.sv
// Scoreboard bench for vc_arb_mux: a 4x32 instance and a 3x8 instance driven on a shared clock/reset.
// Expected arbitration follows VC_ARB_MUX_RR_EN the same way the design build does.
module tb_vc_arb_mux;

  logic        clk;
  logic        reset_n;

  logic [3:0]  in_val4;
  logic [3:0]  in_rdy4;
  logic [127:0] in_msg4;
  logic        out_val4;
  logic        out_rdy4;
  logic [31:0] out_msg4;
  logic [1:0]  out_chan4;

  logic [2:0]  in_val3;
  logic [2:0]  in_rdy3;
  logic [23:0] in_msg3;
  logic        out_val3;
  logic        out_rdy3;
  logic [7:0]  out_msg3;
  logic [1:0]  out_chan3;

  vc_arb_mux u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_val(in_val4), .in_rdy(in_rdy4), .in_msg(in_msg4),
    .out_val(out_val4), .out_rdy(out_rdy4), .out_msg(out_msg4), .out_chan(out_chan4)
  );

  vc_arb_mux #(.NUM_CH(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_val(in_val3), .in_rdy(in_rdy3), .in_msg(in_msg3),
    .out_val(out_val3), .out_rdy(out_rdy3), .out_msg(out_msg3), .out_chan(out_chan3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Reference model state
  logic [33:0] sb4[$];
  logic [9:0]  sb3[$];
  logic        m_val4, m_val3;
  int          m_prio4, m_prio3;
  logic [33:0] m_last4;
  logic [9:0]  m_last3;

  function automatic int arb(input logic [3:0] v, input int p, input int n);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = (p + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int eff_prio(input int p);
`ifdef VC_ARB_MUX_RR_EN
    return p;
`else
    return 0;
`endif
  endfunction

  function automatic logic [3:0] exp_rdy4();
    int g;
    g = arb(in_val4, eff_prio(m_prio4), 4);
    if (g >= 0 && (!m_val4 || out_rdy4)) return 4'b0001 << g;
    return 4'b0000;
  endfunction

  function automatic logic [2:0] exp_rdy3();
    int g;
    g = arb({1'b0, in_val3}, eff_prio(m_prio3), 3);
    if (g >= 0 && (!m_val3 || out_rdy3)) return 3'b001 << g;
    return 3'b000;
  endfunction

  task automatic tick4();
    int   g;
    logic ld;
    g  = arb(in_val4, eff_prio(m_prio4), 4);
    ld = (g >= 0) && (!m_val4 || out_rdy4);
    if (ld) sb4.push_back({2'(g), in_msg4[g*32 +: 32]});
    @(posedge clk); #1;
    if (ld) begin
      m_val4  = 1'b1;
      m_prio4 = (g + 1) % 4;
    end else if (out_rdy4) begin
      m_val4 = 1'b0;
    end
    if (sb4.size() > 0) m_last4 = sb4.pop_front();
  endtask

  task automatic tick3();
    int   g;
    logic ld;
    g  = arb({1'b0, in_val3}, eff_prio(m_prio3), 3);
    ld = (g >= 0) && (!m_val3 || out_rdy3);
    if (ld) sb3.push_back({2'(g), in_msg3[g*8 +: 8]});
    @(posedge clk); #1;
    if (ld) begin
      m_val3  = 1'b1;
      m_prio3 = (g + 1) % 3;
    end else if (out_rdy3) begin
      m_val3 = 1'b0;
    end
    if (sb3.size() > 0) m_last3 = sb3.pop_front();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_val4 = '0; in_msg4 = '0; out_rdy4 = 1'b0;
    in_val3 = '0; in_msg3 = '0; out_rdy3 = 1'b0;
    m_val4 = 1'b0; m_prio4 = 0; m_val3 = 1'b0; m_prio3 = 0;
    m_last4 = '0; m_last3 = '0;
    #3;
    n_total++;
    if ({out_val4, out_msg4, out_chan4, in_rdy4} !== 39'h0) begin
      $display("FAIL reset4: val=%b msg=%h chan=%0d rdy=%b, required all zero", out_val4, out_msg4, out_chan4, in_rdy4);
    end else n_pass++;
    n_total++;
    if ({out_val3, out_msg3, out_chan3, in_rdy3} !== 14'h0) begin
      $display("FAIL reset3: val=%b msg=%h chan=%0d rdy=%b, required all zero", out_val3, out_msg3, out_chan3, in_rdy3);
    end else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_single();
    in_val4  = 4'b0100;
    in_msg4  = {32'h11111111, 32'h0c0c0c0c, 32'h22222222, 32'h33333333};
    out_rdy4 = 1'b1;
    #1;
    n_total++;
    if (in_rdy4 !== 4'b0100) $display("FAIL single_rdy: got %b required 0100", in_rdy4);
    else n_pass++;
    tick4();
    n_total++;
    if (out_val4 !== 1'b1 || out_chan4 !== 2'd2 || out_msg4 !== 32'h0c0c0c0c)
      $display("FAIL single_out: val=%b chan=%0d msg=%h required val=1 chan=2 msg=0c0c0c0c", out_val4, out_chan4, out_msg4);
    else n_pass++;
    $display("single: chan=%0d msg=%h", out_chan4, out_msg4);
  endtask

  task automatic test_contention();
    int p0;
    int want;
    p0 = eff_prio(m_prio4);
    in_val4 = 4'b1111;
    in_msg4 = {32'hd0d0d0d0, 32'h0c0c0c0c, 32'hb0b0b0b0, 32'h0a0a0a0a};
    out_rdy4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_total++;
      if (in_rdy4 !== exp_rdy4()) $display("FAIL contention_rdy[%0d]: got %b required %b", i, in_rdy4, exp_rdy4());
      else n_pass++;
      tick4();
`ifdef VC_ARB_MUX_RR_EN
      want = (p0 + i) % 4;
`else
      want = 0;
`endif
      n_total++;
      if (out_val4 !== 1'b1 || {out_chan4, out_msg4} !== m_last4 || int'(out_chan4) != want)
        $display("FAIL contention_out[%0d]: val=%b chan=%0d msg=%h required val=1 chan=%0d msg=%h", i, out_val4, out_chan4, out_msg4, want, m_last4[31:0]);
      else n_pass++;
      $display("contention[%0d]: chan=%0d msg=%h", i, out_chan4, out_msg4);
    end
  endtask

  task automatic test_backpressure();
    in_val4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      out_rdy4 = (i >= 3);
      #1;
      n_total++;
      if (in_rdy4 !== exp_rdy4() || (i < 3 && in_rdy4 !== 4'b0000))
        $display("FAIL backpressure_rdy[%0d]: got %b required %b", i, in_rdy4, exp_rdy4());
      else n_pass++;
      tick4();
      n_total++;
      if (out_val4 !== 1'b1 || {out_chan4, out_msg4} !== m_last4)
        $display("FAIL backpressure_out[%0d]: val=%b chan=%0d msg=%h required val=1 chan=%0d msg=%h", i, out_val4, out_chan4, out_msg4, m_last4[33:32], m_last4[31:0]);
      else n_pass++;
      $display("backpressure[%0d]: out_rdy=%b chan=%0d msg=%h", i, out_rdy4, out_chan4, out_msg4);
    end
  endtask

  task automatic test_sparse();
    in_val4  = 4'b1010;
    out_rdy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (in_rdy4 !== exp_rdy4()) $display("FAIL sparse_rdy[%0d]: got %b required %b", i, in_rdy4, exp_rdy4());
      else n_pass++;
      tick4();
      n_total++;
      if (out_val4 !== 1'b1 || {out_chan4, out_msg4} !== m_last4)
        $display("FAIL sparse_out[%0d]: val=%b chan=%0d msg=%h required val=1 chan=%0d msg=%h", i, out_val4, out_chan4, out_msg4, m_last4[33:32], m_last4[31:0]);
      else n_pass++;
      $display("sparse[%0d]: chan=%0d msg=%h", i, out_chan4, out_msg4);
    end
  endtask

  task automatic test_reset_mid();
    // Load channel 2 so the pointer sits at 3, then hold the message under backpressure.
    in_val4  = 4'b0100;
    out_rdy4 = 1'b1;
    tick4();
    in_val4  = 4'b0000;
    out_rdy4 = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    sb4.delete();
    m_val4 = 1'b0; m_prio4 = 0;
    n_total++;
    if (out_val4 !== 1'b0 || out_msg4 !== 32'h0 || out_chan4 !== 2'd0)
      $display("FAIL reset_mid: val=%b msg=%h chan=%0d required 0/0/0", out_val4, out_msg4, out_chan4);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    in_val4  = 4'b1111;
    out_rdy4 = 1'b1;
    tick4();
    n_total++;
    if (out_val4 !== 1'b1 || out_chan4 !== 2'd0 || {out_chan4, out_msg4} !== m_last4)
      $display("FAIL reset_mid_first: val=%b chan=%0d msg=%h required val=1 chan=0 msg=%h", out_val4, out_chan4, out_msg4, m_last4[31:0]);
    else n_pass++;
    $display("reset_mid: first chan=%0d msg=%h", out_chan4, out_msg4);
    in_val4 = 4'b0000;
  endtask

  task automatic test_odd();
    int       want;
    logic [7:0] want_msg;
    logic [23:0] msgs;
    in_val3  = 3'b111;
    msgs     = {8'h33, 8'h22, 8'h11};
    in_msg3  = msgs;
    out_rdy3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (in_rdy3 !== exp_rdy3()) $display("FAIL odd_rdy[%0d]: got %b required %b", i, in_rdy3, exp_rdy3());
      else n_pass++;
      tick3();
`ifdef VC_ARB_MUX_RR_EN
      want = i % 3;
`else
      want = 0;
`endif
      want_msg = msgs[want*8 +: 8];
      n_total++;
      if (out_val3 !== 1'b1 || int'(out_chan3) != want || out_msg3 !== want_msg || {out_chan3, out_msg3} !== m_last3)
        $display("FAIL odd_out[%0d]: val=%b chan=%0d msg=%h required val=1 chan=%0d msg=%h", i, out_val3, out_chan3, out_msg3, want, want_msg);
      else n_pass++;
      $display("odd[%0d]: chan=%0d msg=%h", i, out_chan3, out_msg3);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_odd();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
